alu_op_issue: RTL
=================

Name: alu_op_issue

Overview:
- Issue-side producer for the 4-bit-func ALU interface (in1, in2, func).
- Accepts decoded-stage MIPS instructions plus register-file operands and translates opcode/funct into ALU func codes.
- Forms the in1/in2 operands, including immediate extension, and buffers issued operations in a small FIFO.
- Presents them to the ALU pipeline register with a valid/ready handshake. Sits between register read and execute in each superscalar lane.

Parameters:
- DEPTH, 2, issue FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous flush; empties FIFO (branch mispredict).
- in_valid  in  1  instruction/operands valid.
- in_ready  out  1  block can accept this cycle.
- instr  in  32  MIPS instruction word.
- rs_data  in  32  register rs value.
- rt_data  in  32  register rt value.
- out_valid  out  1  head entry valid.
- out_ready  in  1  ALU stage consumes head.
- out_in1  out  32  ALU operand 1.
- out_in2  out  32  ALU operand 2.
- out_func  out  4  ALU function code.
- out_dest  out  5  destination register.
- illegal  out  1  one-cycle pulse: unsupported instruction accepted and dropped.

Behaviour:
- Func codes: AND 0000, OR 0001, XOR 0010, XNOR 0011, ADD 0100, SUB 1100, SLT 1101, SLTU 0110.
- R-type (opcode 0x00), in1=rs_data, in2=rt_data, dest=instr[15:11]:
  - funct 0x20/0x21 -> 0100
  - funct 0x22/0x23 -> 1100
  - funct 0x24 -> 0000
  - funct 0x25 -> 0001
  - funct 0x26 -> 0010
  - funct 0x2A -> 1101
  - funct 0x2B -> 0110
  - any other funct is illegal.
- I-type, in1=rs_data, dest=instr[20:16]:
  - sign-extended imm: addi 0x08 / addiu 0x09 -> 0100; slti 0x0A -> 1101; sltiu 0x0B -> 0110.
  - zero-extended imm: andi 0x0C -> 0000; ori 0x0D -> 0001; xori 0x0E -> 0010.
  - lui 0x0F: in1=0, in2={imm,16'h0}, func 0001.
  - any other opcode is illegal.
- Accept: when in_valid && in_ready at a rising edge.
  - Legal instructions are written to the FIFO tail.
  - Illegal instructions are not written; illegal=1 for the following cycle only.
- in_ready = (count < DEPTH), registered-state derived; it does not depend on out_ready, so there is no combinational ready path.
- Pop: when out_valid && out_ready at the edge.
- Outputs are driven from the head entry. out_valid = (count != 0).
- Latency: accept at edge N gives out_valid=1 after edge N when the FIFO was empty. There is no same-cycle bypass.
- Full-rate operation: push and pop in the same edge with 0 < count < DEPTH leaves count unchanged and moves both head and tail.
- Full: in_ready=0. A pop in that cycle frees the slot for the next cycle only.
- Empty: out_valid=0. out_* hold the last head value (don't-care for consumers).
- Pointers wrap modulo DEPTH.
- flush=1:
  - count, head and tail go to 0 at the edge; out_valid=0 next cycle.
  - Any push or pop that cycle is discarded.
  - illegal is not raised for an instruction presented during flush.
- rst=1 (any time, including mid-operation) immediately forces:
  - count=0, pointers 0, out_valid=0, illegal=0
  - out_in1/out_in2=0, out_func=0000, out_dest=0
  - in_ready=1 once rst deasserts.
- Operands are captured at accept. Later changes on rs_data/rt_data do not alter queued entries.

Test Plan:
- Reset then issue add rs=78375, rt=42596, rd=3; out_ready=1. Next cycle: out_valid=1, in1=78375, in2=42596, func=0100, dest=3. The following cycle: out_valid=0.
- Immediate forms:
  - addi rs=5, imm=0xFFFF -> in2=0xFFFFFFFF, func 0100.
  - andi imm=0x8000 -> in2=0x00008000, func 0000.
  - lui imm=0x1234 -> in1=0, in2=0x12340000, func 0001.
  - sltiu imm=0x000F, rs=0xFFFFFFFF -> in2=0x0000000F, func 0110.
- Back-pressure with DEPTH=2 and out_ready=0: push sub then slt, then present xor.
  - in_ready=0 after the second accept; xor is held off.
  - Raise out_ready: pops are in order sub(1100), slt(1101), xor(0010).
  - in_ready returns to 1 the cycle after the first pop.
- Streaming: in_valid=1 and out_ready=1 for 8 cycles with distinct rs_data -> 8 outputs in order, count never exceeds 1, no bubbles after the first.
- Illegal R-type funct 0x27 (nor), then opcode 0x23 (lw) -> one-cycle illegal pulse for each, out_valid stays 0, FIFO unchanged.
- Fill the FIFO, then pulse flush with a simultaneous push -> out_valid=0 next cycle and the pushed entry is absent. Assert rst asynchronously with 1 entry queued -> outputs zero immediately, before the next clock edge.

Source files
------------

// File: rtl/alu_op_issue_if.sv
// Issue-lane bundle between register read (producer of instructions/operands)
// and the ALU pipeline register (consumer of in1/in2/func/dest).
interface alu_op_issue_if;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_in1;
  logic [31:0] out_in2;
  logic [3:0]  out_func;
  logic [4:0]  out_dest;
  logic        illegal;

  // Driver of decoded instructions and the ALU-side ready.
  modport master (
    output flush, in_valid, instr, rs_data, rt_data, out_ready,
    input  in_ready, out_valid, out_in1, out_in2, out_func, out_dest, illegal
  );

  // The issue block itself.
  modport slave (
    input  flush, in_valid, instr, rs_data, rt_data, out_ready,
    output in_ready, out_valid, out_in1, out_in2, out_func, out_dest, illegal
  );
endinterface

// File: rtl/alu_op_issue.sv
// ALU op issue: decodes MIPS ALU instructions into 4-bit ALU func codes,
// forms in1/in2 (with immediate extension) and queues them in a small FIFO
// that feeds the ALU pipeline register over valid/ready.
module alu_op_issue #(
  parameter int DEPTH = 2
) (
  input logic          clk,
  input logic          rst,
  alu_op_issue_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [3:0] F_AND  = 4'b0000;
  localparam logic [3:0] F_OR   = 4'b0001;
  localparam logic [3:0] F_XOR  = 4'b0010;
  localparam logic [3:0] F_ADD  = 4'b0100;
  localparam logic [3:0] F_SUB  = 4'b1100;
  localparam logic [3:0] F_SLT  = 4'b1101;
  localparam logic [3:0] F_SLTU = 4'b0110;

  typedef struct packed {
    logic [31:0] in1;
    logic [31:0] in2;
    logic [3:0]  func;
    logic [4:0]  dest;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic            illegal_q, illegal_d;

  entry_t          dec;
  logic            legal;
  logic            accept;
  logic            push;
  logic            pop;

  logic [5:0]      opcode;
  logic [5:0]      funct;
  logic [15:0]     imm;

  assign opcode = bus.instr[31:26];
  assign funct  = bus.instr[5:0];
  assign imm    = bus.instr[15:0];

  // Decode opcode/funct into an ALU entry; anything unrecognised is illegal.
  always_comb begin
    dec.in1  = bus.rs_data;
    dec.in2  = bus.rt_data;
    dec.func = F_AND;
    dec.dest = bus.instr[20:16];
    legal    = 1'b1;
    if (opcode == 6'h00) begin
      dec.dest = bus.instr[15:11];
      case (funct)
        6'h20, 6'h21: dec.func = F_ADD;
        6'h22, 6'h23: dec.func = F_SUB;
        6'h24:        dec.func = F_AND;
        6'h25:        dec.func = F_OR;
        6'h26:        dec.func = F_XOR;
        6'h2A:        dec.func = F_SLT;
        6'h2B:        dec.func = F_SLTU;
        default:      legal    = 1'b0;
      endcase
    end else begin
      case (opcode)
        6'h08, 6'h09: begin dec.in2 = {{16{imm[15]}}, imm}; dec.func = F_ADD;  end
        6'h0A:        begin dec.in2 = {{16{imm[15]}}, imm}; dec.func = F_SLT;  end
        6'h0B:        begin dec.in2 = {{16{imm[15]}}, imm}; dec.func = F_SLTU; end
        6'h0C:        begin dec.in2 = {16'h0000, imm};      dec.func = F_AND;  end
        6'h0D:        begin dec.in2 = {16'h0000, imm};      dec.func = F_OR;   end
        6'h0E:        begin dec.in2 = {16'h0000, imm};      dec.func = F_XOR;  end
        6'h0F: begin
          dec.in1  = 32'h0000_0000;
          dec.in2  = {imm, 16'h0000};
          dec.func = F_OR;
        end
        default: legal = 1'b0;
      endcase
    end
  end

  // Ready comes only from registered occupancy, so there is no ready path
  // from the ALU side back to the producer.
  assign bus.in_ready  = (count_q < DEPTH_C);
  assign bus.out_valid = (count_q != '0);
  assign bus.out_in1   = mem_q[head_q].in1;
  assign bus.out_in2   = mem_q[head_q].in2;
  assign bus.out_func  = mem_q[head_q].func;
  assign bus.out_dest  = mem_q[head_q].dest;
  assign bus.illegal   = illegal_q;

  assign accept = bus.in_valid && bus.in_ready && !bus.flush;
  assign push   = accept && legal;
  assign pop    = bus.out_valid && bus.out_ready && !bus.flush;

  // Next-state for pointers, occupancy and the illegal pulse; flush wins.
  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    illegal_d = accept && !legal;
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + PW'(1);
      if (pop)  head_d = head_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State and storage; storage is cleared on reset so outputs read zero at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      illegal_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
      if (push) mem_q[tail_q] <= dec;
    end
  end

endmodule
